op_stack: RTL

Operator-stack sequencer for the calculator's shunting-yard parser. It takes the operator token stream from the lexer, one `CO_*` code per token. It holds pending operators on an internal LIFO and releases them in postfix order to the evaluator, using the four-level operator precedence ordering. It sits between the lexer (upstream, valid/ready) and the evaluator (downstream, valid/ready), and latches sticky error codes for malformed expressions.

---
 rtl/op_stack.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/op_stack.sv
// Operator-stack sequencer for the shunting-yard parser: holds pending operators
// on a LIFO and releases them to the evaluator in postfix order.
module op_stack #(
  parameter int DEPTH = 16,
  parameter int CO_N  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CO_N-1:0]            in_op,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [CO_N-1:0]            out_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       done,
  output logic [1:0]                 err,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_L = DW'(DEPTH);

  localparam logic [CO_N-1:0] CO_OK = CO_N'(0);
  localparam logic [CO_N-1:0] CO_LP = CO_N'(1);
  localparam logic [CO_N-1:0] CO_RP = CO_N'(2);
  localparam logic [CO_N-1:0] CO_AD = CO_N'(3);
  localparam logic [CO_N-1:0] CO_SB = CO_N'(4);
  localparam logic [CO_N-1:0] CO_MU = CO_N'(5);
  localparam logic [CO_N-1:0] CO_DI = CO_N'(6);
  localparam logic [CO_N-1:0] CO_PS = CO_N'(7);
  localparam logic [CO_N-1:0] CO_NS = CO_N'(8);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_EMIT, S_ERR} state_t;

  state_t          state_reg;
  logic [CO_N-1:0] cur_reg;
  logic [CO_N-1:0] top_reg;
  logic [CO_N-1:0] out_op_reg;
  logic            out_valid_reg;
  logic            done_reg;
  logic [1:0]      err_reg;
  logic [DW-1:0]   depth_reg;

  logic [CO_N-1:0] stack_mem [DEPTH];

  function automatic logic [1:0] level(input logic [CO_N-1:0] op);
    case (op)
      CO_AD, CO_SB: level = 2'd1;
      CO_MU, CO_DI: level = 2'd2;
      CO_PS, CO_NS: level = 2'd3;
      default:      level = 2'd0;
    endcase
  endfunction

  logic            empty;
  logic            full;
  logic            top_is_lp;
  logic            push_req;
  logic            emit_req;
  logic            pop_lp;
  logic [1:0]      eval_err;
  logic [CO_N-1:0] emit_op;
  logic            push_en;
  logic [DW-1:0]   rd_ptr;

  assign empty     = (depth_reg == '0);
  assign full      = (depth_reg == DEPTH_L);
  assign top_is_lp = (top_reg == CO_LP);
  assign emit_op   = empty ? CO_OK : top_reg;
  assign push_en   = (state_reg == S_EVAL) && push_req;

  // EVAL decision for the current token against the current top of stack.
  always_comb begin
    push_req = 1'b0;
    emit_req = 1'b0;
    pop_lp   = 1'b0;
    eval_err = 2'd0;
    case (cur_reg)
      CO_LP, CO_PS, CO_NS: push_req = 1'b1;
      CO_AD, CO_SB, CO_MU, CO_DI: begin
        if (!empty && !top_is_lp && (level(top_reg) >= level(cur_reg)))
          emit_req = 1'b1;
        else
          push_req = 1'b1;
      end
      CO_RP: begin
        if (empty)          eval_err = 2'd2;
        else if (top_is_lp) pop_lp   = 1'b1;
        else                emit_req = 1'b1;
      end
      CO_OK: begin
        if (empty)          emit_req = 1'b1;
        else if (top_is_lp) eval_err = 2'd2;
        else                emit_req = 1'b1;
      end
      default: eval_err = 2'd3;
    endcase
    if (push_req && full) begin
      push_req = 1'b0;
      eval_err = 2'd1;
    end
  end

  // The top is read one cycle ahead: in EMIT the pending pop means the next
  // EVAL sees the entry below the current top.
  assign rd_ptr = (state_reg == S_EMIT) ? (depth_reg - DW'(2)) : (depth_reg - DW'(1));

  always_ff @(posedge clk) begin
    if (push_en)
      stack_mem[depth_reg[AW-1:0]] <= cur_reg;
    if (rd_ptr < DEPTH_L)
      top_reg <= stack_mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cur_reg       <= '0;
      out_op_reg    <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 2'd0;
      depth_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            cur_reg   <= in_op;
            state_reg <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (eval_err != 2'd0) begin
            err_reg   <= eval_err;
            state_reg <= S_ERR;
          end else if (push_req) begin
            depth_reg <= depth_reg + DW'(1);
            state_reg <= S_IDLE;
          end else if (pop_lp) begin
            depth_reg <= depth_reg - DW'(1);
            state_reg <= S_IDLE;
          end else if (emit_req) begin
            out_op_reg    <= emit_op;
            out_valid_reg <= 1'b1;
            state_reg     <= S_EMIT;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            // OK is never stacked, so an emitted OK is always the terminal one.
            if (out_op_reg == CO_OK) begin
              done_reg  <= 1'b1;
              depth_reg <= '0;
              state_reg <= S_IDLE;
            end else begin
              depth_reg <= depth_reg - DW'(1);
              state_reg <= S_EVAL;
            end
          end
        end
        default: state_reg <= S_ERR;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_op    = out_op_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign depth     = depth_reg;

endmodule
